serial_pattern_gen: RTL

- Upstream stimulus stage for the Moore sequence detector.
- Accepts a parallel pattern word on a single-cycle load, then emits it MSB-first as a one-bit serial stream, one bit per clock.
- `out_bit` drives the detector's serial input `in`.
- Fixed inter-word gap of zeros guarantees detector state separation between words.

---
 rtl/serial_pattern_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_pattern_gen.sv
// Parallel-load, MSB-first serial pattern generator feeding the sequence detector input.
// Optional build macro PATTERN_LOOP_EN adds a `loop` input that repeats the captured word back to back.
module serial_pattern_gen #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
`ifdef PATTERN_LOOP_EN
    input  logic             loop,
`endif
    output logic             ready,
    output logic             out_bit,
    output logic             bit_valid,
    output logic [1:0]       state_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0] LAST_GAP = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Code 2'b11 is never entered on purpose; it falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        GAP    = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [3:0]       gap_cnt, gap_cnt_nxt;
`ifdef PATTERN_LOOP_EN
    logic [WIDTH-1:0] hold, hold_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
`ifdef PATTERN_LOOP_EN
            hold    <= '0;
`endif
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
`ifdef PATTERN_LOOP_EN
            hold    <= hold_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
`ifdef PATTERN_LOOP_EN
        hold_nxt    = hold;
`endif
        ready       = 1'b0;
        out_bit     = 1'b0;
        bit_valid   = 1'b0;
        state_out   = state;

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    shreg_nxt   = data_in;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
`ifdef PATTERN_LOOP_EN
                    hold_nxt    = data_in;
`endif
                end
            end
            SHIFT: begin
                out_bit     = shreg[WIDTH-1];
                bit_valid   = 1'b1;
                shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
                bit_cnt_nxt = bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_nxt = '0;
`ifdef PATTERN_LOOP_EN
                    // Reload without leaving SHIFT so the repeated stream has no hole.
                    if (loop) begin
                        shreg_nxt = hold;
                    end else
`endif
                    if (GAP_CYCLES > 0) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
